// File: rtl/mdio_master_pkg.sv
// Shared MDIO framing constants, FSM state type and read-opcode decode.
package mdio_master_pkg;
  localparam int MDIO_PRE_BITS   = 32;
  localparam int MDIO_FRAME_BITS = 32;
  localparam int RD_TA_BIT       = 17;  // first bit released on a read (TA[1])
  localparam int RD_DATA_MSB     = 15;

  localparam logic [1:0] MDIO_ST_C22 = 2'b01;
  localparam logic [1:0] MDIO_ST_C45 = 2'b00;
  localparam logic [1:0] C45_ADDR    = 2'b00;
  localparam logic [1:0] C45_WR      = 2'b01;
  localparam logic [1:0] C45_RDINC   = 2'b10;
  localparam logic [1:0] C45_RD      = 2'b11;
  localparam logic [1:0] C22_WR      = 2'b01;
  localparam logic [1:0] C22_RD      = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_TAIL} state_e;

  function automatic logic frame_is_rd(input logic [31:0] w);
    return (w[31:30] == MDIO_ST_C45 && w[29]) ||
           (w[31:30] == MDIO_ST_C22 && w[29:28] == C22_RD);
  endfunction
endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: MDC_DIV clk per half-period, strobes on the cycle before each mdc edge.
module mdio_master_mdc_gen #(
  parameter int MDC_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int CW = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;
  logic          tc;

  assign tc = (div_q == CW'(MDC_DIV - 1));

  always_comb begin
    div_d = div_q + CW'(1);
    mdc_d = mdc_q;
    if (tc) begin
      div_d = '0;
      mdc_d = ~mdc_q;
    end
    if (!en_i) begin
      div_d = '0;
      mdc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc_o      = mdc_q;
  assign rise_stb_o = en_i && tc && !mdc_q;
  assign fall_stb_o = en_i && tc &&  mdc_q;
endmodule

// File: rtl/mdio_master.sv
// MDIO master: serialises preamble + 32-bit access word, releases the bus and captures data on reads.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int MDC_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] acc_data,
  input  logic        acc_en,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        acc_drop
);
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, cnt_nxt;
  logic [31:0] sh_q, sh_d;
  logic [15:0] rdsh_q, rdsh_d, rd_data_q, rd_data_d;
  logic        is_rd_q, is_rd_d;
  logic        mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic        busy_q, busy_d, rd_valid_d, rd_valid_q, acc_drop_d, acc_drop_q;
  logic        rise_stb, fall_stb;

  mdio_master_mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != S_IDLE),
    .mdc_o     (mdc),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  assign cnt_nxt = cnt_q - 6'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rdsh_d     = rdsh_q;
    rd_data_d  = rd_data_q;
    is_rd_d    = is_rd_q;
    mdio_o_d   = mdio_o_q;
    mdio_t_d   = mdio_t_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    acc_drop_d = acc_en && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        mdio_o_d = 1'b1;
        mdio_t_d = 1'b1;
        busy_d   = 1'b0;
        if (acc_en) begin
          state_d  = S_PRE;
          sh_d     = acc_data;
          is_rd_d  = frame_is_rd(acc_data);
          cnt_d    = 6'(MDIO_PRE_BITS - 1);
          busy_d   = 1'b1;
          mdio_t_d = 1'b0;
        end
      end
      S_PRE: begin
        if (fall_stb) begin
          if (cnt_q == '0) begin
            state_d  = S_FRAME;
            cnt_d    = 6'(MDIO_FRAME_BITS - 1);
            mdio_o_d = sh_q[31];
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      S_FRAME: begin
        // cnt_q is the acc_data bit index currently on the wire
        if (rise_stb && is_rd_q && cnt_q <= 6'(RD_DATA_MSB))
          rdsh_d = {rdsh_q[14:0], mdio_i};
        if (fall_stb) begin
          if (cnt_q == '0) begin
            state_d  = S_TAIL;
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b1;
          end else begin
            cnt_d    = cnt_nxt;
            sh_d     = {sh_q[30:0], 1'b0};
            mdio_o_d = sh_q[30];
            mdio_t_d = is_rd_q && (cnt_nxt <= 6'(RD_TA_BIT));
          end
        end
      end
      S_TAIL: begin
        if (fall_stb) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (is_rd_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rdsh_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rdsh_q     <= '0;
      rd_data_q  <= '0;
      is_rd_q    <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_t_q   <= 1'b1;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      acc_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rdsh_q     <= rdsh_d;
      rd_data_q  <= rd_data_d;
      is_rd_q    <= is_rd_d;
      mdio_o_q   <= mdio_o_d;
      mdio_t_q   <= mdio_t_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      acc_drop_q <= acc_drop_d;
    end
  end

  assign mdio_o   = mdio_o_q;
  assign mdio_t   = mdio_t_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign acc_drop = acc_drop_q;
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master at MDC_DIV=2 with a PHY model answering reads on mdio_i.
module tb_mdio_master;
  logic        clk = 1'b0, rst = 1'b1, acc_en = 1'b0, mdio_i = 1'b1;
  logic [31:0] acc_data = '0;
  logic        mdc, mdio_o, mdio_t, busy, rd_valid, acc_drop;
  logic [15:0] rd_data;

  mdio_master #(.MDC_DIV(2)) dut (
    .clk(clk), .rst(rst), .acc_data(acc_data), .acc_en(acc_en),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .acc_drop(acc_drop)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;

  // monitor / PHY model state, sampled on the falling clk edge
  logic [15:0] phy_data = 16'h0;
  logic [31:0] pre_vec, frm_vec;
  logic [63:0] t_vec;
  logic        tail_t;
  int fc = 0, hi_run = 0, lo_run = 0, per_err = 0, glitch = 0, rises = 0;
  int busy_tot = 0, rdv_tot = 0, drop_tot = 0;
  logic pm = 1'b0, pb = 1'b0, po = 1'b1, pt = 1'b1;

  always @(negedge clk) begin
    if (busy && !pb) fc = 0;
    if (!mdc && pm) fc = fc + 1;
    if (mdc && !pm) begin
      rises = rises + 1;
      if (fc < 32)       pre_vec[31-fc] = mdio_o;
      else if (fc < 64)  frm_vec[63-fc] = mdio_o;
      if (fc >= 32 && fc < 64) t_vec[63-fc] = mdio_t;
      if (fc == 64) tail_t = mdio_t;
    end
    mdio_i = (busy && fc >= 48 && fc <= 63) ? phy_data[63-fc] : 1'b1;
    if ((mdio_o !== po || mdio_t !== pt) && mdc) glitch = glitch + 1;
    if (rst) begin
      hi_run = 0; lo_run = 0;
    end else begin
      if (mdc && !pm) begin
        if (lo_run != 2) per_err = per_err + 1;
        lo_run = 0; hi_run = 0;
      end
      if (!mdc && pm) begin
        if (hi_run != 2) per_err = per_err + 1;
        hi_run = 0;
      end
      if (mdc) hi_run = hi_run + 1;
      else if (busy) lo_run = lo_run + 1;
      else lo_run = 0;
    end
    if (busy) busy_tot = busy_tot + 1;
    if (rd_valid) rdv_tot = rdv_tot + 1;
    if (acc_drop) drop_tot = drop_tot + 1;
    pm = mdc; pb = busy; po = mdio_o; pt = mdio_t;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [31:0] d);
    acc_data = d; acc_en = 1'b1; tick(); acc_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin tick(); n++; end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  int b0, r0, d0;

  initial begin
    repeat (3) tick();
    chk("rst_mdc", mdc, 0);        chk("rst_mdio_o", mdio_o, 1);
    chk("rst_mdio_t", mdio_t, 1);  chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0); chk("rst_rd_valid", rd_valid, 0);
    chk("rst_acc_drop", acc_drop, 0);
    rst = 1'b0; tick();

    // C45 address write
    b0 = busy_tot; r0 = rdv_tot;
    start(32'h0006_0000);
    chk("wr_start_busy", busy, 1); chk("wr_start_t", mdio_t, 0);
    chk("wr_start_o", mdio_o, 1);  chk("wr_start_mdc", mdc, 0);
    wait_idle(); tick();
    chk("wr_pre", pre_vec, 32'hFFFF_FFFF);
    chk("wr_frame", frm_vec, 32'h0006_0000);
    chk("wr_t", t_vec, 64'h0);
    chk("wr_tail_t", tail_t, 1);
    chk("wr_busy_len", busy_tot - b0, 260);
    chk("wr_no_rdv", rdv_tot - r0, 0);

    // C45 read
    phy_data = 16'hBEEF; b0 = busy_tot; r0 = rdv_tot;
    start(32'h3006_0000);
    wait_idle();
    chk("c45rd_valid_at_fall", rd_valid, 1);
    chk("c45rd_data", rd_data, 16'hBEEF);
    tick();
    chk("c45rd_t", t_vec, 64'h0000_0000_0003_FFFF);
    chk("c45rd_hdr", frm_vec[31:18], 14'(32'h3006_0000 >> 18));
    chk("c45rd_busy_len", busy_tot - b0, 260);
    chk("c45rd_rdv_once", rdv_tot - r0, 1);

    // C22 read then C22 write
    phy_data = 16'h1234; r0 = rdv_tot;
    start(32'h6002_0000);
    wait_idle(); tick();
    chk("c22rd_data", rd_data, 16'h1234);
    chk("c22rd_t", t_vec, 64'h0000_0000_0003_FFFF);
    start(32'h5002_5A5A);
    wait_idle(); tick();
    chk("c22wr_frame", frm_vec, 32'h5002_5A5A);
    chk("c22wr_keeps_rd", rd_data, 16'h1234);
    chk("c22_rdv_total", rdv_tot - r0, 1);

    // requests while busy are dropped; first idle cycle accepts
    b0 = busy_tot; d0 = drop_tot;
    start(32'h1005_ABCD);
    repeat (10) tick();
    acc_data = 32'hFFFF_FFFF; acc_en = 1'b1; tick(); acc_en = 1'b0;
    repeat (248) tick();
    chk("drop_busy_259", busy, 1);
    acc_data = 32'hFFFF_FFFF; acc_en = 1'b1; tick(); acc_en = 1'b0;
    chk("drop_idle_260", busy, 0);
    chk("drop_pulse_late", acc_drop, 1);
    chk("drop_frame", frm_vec, 32'h1005_ABCD);
    b0 = busy_tot - b0;
    chk("drop_busy_len", b0, 260);
    b0 = busy_tot;
    start(32'h1007_0F0F);
    chk("b2b_busy", busy, 1);
    wait_idle(); tick();
    chk("drop_count", drop_tot - d0, 2);
    chk("b2b_frame", frm_vec, 32'h1007_0F0F);
    chk("b2b_busy_len", busy_tot - b0, 260);

    // reset mid-read
    phy_data = 16'hCAFE; r0 = rdv_tot;
    start(32'h3006_0000);
    repeat (100) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_mdc", mdc, 0);      chk("abort_t", mdio_t, 1);
    chk("abort_busy", busy, 0);    chk("abort_rd_data", rd_data, 0);
    chk("abort_rd_valid", rd_valid, 0);
    repeat (5) tick();
    chk("abort_no_rdv", rdv_tot - r0, 0);
    b0 = busy_tot;
    start(32'h0006_0000);
    wait_idle(); tick();
    chk("post_abort_frame", frm_vec, 32'h0006_0000);
    chk("post_abort_busy_len", busy_tot - b0, 260);
    chk("post_abort_rd_data", rd_data, 0);

    chk("mdc_rises_seen", {63'd0, rises > 300}, 64'd1);
    chk("mdc_period", per_err, 0);
    chk("mdio_stable_mdc_high", glitch, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
